// File: rtl/trace_event_tx_if.sv
// trace_event_tx_if
//   Valid/ready stream carrying 16-bit tagged trace words.
//   tx_valid : word on tx_data is offered this cycle
//   tx_data  : tagged trace word
//   tx_ready : sink accepts the word; transfer on tx_valid && tx_ready
//   master modport = producer (trace_event_tx), slave modport = consumer.
interface trace_event_tx_if;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/trace_event_tx.sv
// trace_event_tx
//   Commit-trace producer. Samples per-cycle retire events (register write,
//   load, store), queues one FIFO entry per event cycle and serializes each
//   entry as REG / LOAD / STORE records of 16-bit tagged words. On halt the
//   cycle and instruction counts are appended as a HALT summary record.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reg_wr_i/reg_id_i/reg_data_i : register writeback event
//   mem_rd_i, mem_wr_i         : load / store event
//   mem_addr_i, mem_wdata_i, mem_rdata_i : memory event payload
//   halt_i                     : halt reached the memory stage
//   ic_req_i, ic_hit_i, dc_req_i, dc_hit_i : cache event strobes
//   tx                         : output stream (trace_event_tx_if.master)
//   tx_done_o                  : summary record fully transmitted
//   overflow_o                 : sticky, an event cycle was dropped
//   drop_cnt_o                 : dropped event cycles, saturating at 0xFF
//
// Build option
//   TRACE_CACHE_STATS_EN : adds 16-bit ic_req/ic_hit/dc_req/dc_hit counters,
//   appended to the HALT record (9 words instead of 5).
//
// States
//   IDLE     | no word offered; waiting for an entry or for halt
//   HDR      | header of the current record offered
//   W1       | first payload word (reg data or address) offered
//   W2       | second payload word (rdata or wdata) offered
//   HALT_HDR | HALT header 0xF000 offered
//   SUM      | summary word idx_q offered
//   DONE     | summary sent; terminal until reset
module trace_event_tx #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_wr_i,
    input  logic [2:0]       reg_id_i,
    input  logic [15:0]      reg_data_i,
    input  logic             mem_rd_i,
    input  logic             mem_wr_i,
    input  logic [15:0]      mem_addr_i,
    input  logic [15:0]      mem_wdata_i,
    input  logic [15:0]      mem_rdata_i,
    input  logic             halt_i,
    input  logic             ic_req_i,
    input  logic             ic_hit_i,
    input  logic             dc_req_i,
    input  logic             dc_hit_i,
    trace_event_tx_if.master tx,
    output logic             tx_done_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR      = 3'd1;
    localparam logic [2:0] S_W1       = 3'd2;
    localparam logic [2:0] S_W2       = 3'd3;
    localparam logic [2:0] S_HALT_HDR = 3'd4;
    localparam logic [2:0] S_SUM      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

`ifdef TRACE_CACHE_STATS_EN
    localparam logic [2:0] SUM_LAST = 3'd7;
`else
    localparam logic [2:0] SUM_LAST = 3'd3;
`endif

    // flags: bit0 REG, bit1 LOAD, bit2 STORE (emission order = bit order)
    typedef struct packed {
        logic [2:0]  flags;
        logic [2:0]  reg_id;
        logic [15:0] reg_data;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } entry_t;

    logic [2:0]  state_q, state_d;
    logic [2:0]  rem_q, rem_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        halt_pend_q;
    logic [31:0] cycle_cnt_q, inst_cnt_q;
    logic        overflow_q;
    logic [7:0]  drop_cnt_q;

    entry_t      fifo_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, count;
    logic [AW-1:0] rd_nxt_idx;
    entry_t      new_entry, head, next_head, cand;
    logic        has_event, full, push, pop, drop, cand_ok;
    logic        xfer, rec_done, take_next;
    logic [2:0]  rem_left, sum_sel;
    logic [15:0] sum_word;

    assign new_entry  = {mem_wr_i, mem_rd_i, reg_wr_i, reg_id_i, reg_data_i,
                         mem_addr_i, mem_wdata_i, mem_rdata_i};
    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == (AW+1)'(DEPTH));
    assign has_event  = reg_wr_i | mem_rd_i | mem_wr_i;
    // The entry being serialized keeps its slot until its last word leaves,
    // so a pop in the same cycle frees room for the push.
    assign push       = has_event && !halt_pend_q && (!full || pop);
    assign drop       = has_event && !halt_pend_q && full && !pop;
    assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign next_head  = fifo_q[rd_nxt_idx];
    assign xfer       = tx_valid_q && tx.tx_ready;
    assign rem_left   = rem_q & (rem_q - 3'd1);
    assign sum_sel    = (state_q == S_SUM) ? idx_q + 3'd1 : 3'd0;

    function automatic logic [15:0] hdr_word(input logic [2:0] flags, input logic [2:0] id);
        if (flags[0])      return {4'h1, 9'b0, id};
        else if (flags[1]) return 16'h2000;
        else               return 16'h3000;
    endfunction

`ifdef TRACE_CACHE_STATS_EN
    logic [15:0] ic_req_cnt_q, ic_hit_cnt_q, dc_req_cnt_q, dc_hit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_req_cnt_q <= '0;
            ic_hit_cnt_q <= '0;
            dc_req_cnt_q <= '0;
            dc_hit_cnt_q <= '0;
        end else if (!halt_pend_q) begin
            ic_req_cnt_q <= ic_req_cnt_q + 16'(ic_req_i);
            ic_hit_cnt_q <= ic_hit_cnt_q + 16'(ic_hit_i);
            dc_req_cnt_q <= dc_req_cnt_q + 16'(dc_req_i);
            dc_hit_cnt_q <= dc_hit_cnt_q + 16'(dc_hit_i);
        end
    end
`else
    logic unused_cache;
    assign unused_cache = ^{ic_req_i, ic_hit_i, dc_req_i, dc_hit_i};
`endif

    always_comb begin
        sum_word = 16'h0;
        case (sum_sel)
            3'd0:    sum_word = cycle_cnt_q[31:16];
            3'd1:    sum_word = cycle_cnt_q[15:0];
            3'd2:    sum_word = inst_cnt_q[31:16];
            3'd3:    sum_word = inst_cnt_q[15:0];
`ifdef TRACE_CACHE_STATS_EN
            3'd4:    sum_word = ic_req_cnt_q;
            3'd5:    sum_word = ic_hit_cnt_q;
            3'd6:    sum_word = dc_req_cnt_q;
            3'd7:    sum_word = dc_hit_cnt_q;
`endif
            default: sum_word = 16'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        rec_done   = 1'b0;
        take_next  = 1'b0;
        case (state_q)
            S_IDLE: take_next = 1'b1;
            S_HDR: if (xfer) begin
                state_d   = S_W1;
                tx_data_d = rem_q[0] ? head.reg_data : head.addr;
            end
            S_W1: if (xfer) begin
                if (rem_q[0]) begin
                    rec_done = 1'b1;
                end else begin
                    state_d   = S_W2;
                    tx_data_d = rem_q[1] ? head.rdata : head.wdata;
                end
            end
            S_W2: if (xfer) rec_done = 1'b1;
            S_HALT_HDR: if (xfer) begin
                state_d   = S_SUM;
                idx_d     = 3'd0;
                tx_data_d = sum_word;
            end
            S_SUM: if (xfer) begin
                if (idx_q == SUM_LAST) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 16'h0;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    tx_data_d = sum_word;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (rec_done) begin
            if (rem_left != 3'd0) begin
                state_d   = S_HDR;
                rem_d     = rem_left;
                tx_data_d = hdr_word(rem_left, head.reg_id);
            end else begin
                pop       = 1'b1;
                take_next = 1'b1;
            end
        end

        // When the head is popped this cycle, the following entry is next.
        cand    = pop ? next_head : head;
        cand_ok = pop ? (count > (AW+1)'(1)) : (count != '0);
        if (take_next) begin
            if (cand_ok) begin
                state_d    = S_HDR;
                rem_d      = cand.flags;
                tx_valid_d = 1'b1;
                tx_data_d  = hdr_word(cand.flags, cand.reg_id);
            end else if (halt_pend_q) begin
                state_d    = S_HALT_HDR;
                tx_valid_d = 1'b1;
                tx_data_d  = 16'hF000;
            end else begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 16'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            idx_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            halt_pend_q <= 1'b0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            if (!halt_pend_q) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
                if (halt_i | reg_wr_i | mem_wr_i) inst_cnt_q <= inst_cnt_q + 32'd1;
                if (halt_i) halt_pend_q <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign tx_done_o   = (state_q == S_DONE);
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_trace_event_tx.sv
module tb_trace_event_tx;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        reg_wr, mem_rd, mem_wr, halt, ic_req, ic_hit, dc_req, dc_hit;
    logic [2:0]  reg_id;
    logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
    logic        tx_done, overflow;
    logic [7:0]  drop_cnt;

    trace_event_tx_if bus();

    trace_event_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_wr_i(reg_wr), .reg_id_i(reg_id), .reg_data_i(reg_data),
        .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_i(mem_rdata),
        .halt_i(halt),
        .ic_req_i(ic_req), .ic_hit_i(ic_hit), .dc_req_i(dc_req), .dc_hit_i(dc_hit),
        .tx(bus),
        .tx_done_o(tx_done), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected word stream, words left per queued entry,
    // counters and flags derived from the event rules.
    logic [15:0] expq[$];
    int          ent_left[$];
    bit          m_halted, m_done, m_ovf;
    int          m_drop, sum_left;
    logic [31:0] m_cyc, m_inst;
    logic [15:0] m_icr, m_ich, m_dcr, m_dch;
    bit          prev_stall;
    logic [15:0] prev_data;
    logic [15:0] log_q[$];
    int          log_t[$];
    logic [15:0] want[$];
    int          step_no = 0;

    task automatic clr_in();
        reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0;
        ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
        reg_id = 0; reg_data = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    endtask

    task automatic model_clear();
        expq.delete(); ent_left.delete(); log_q.delete(); log_t.delete();
        m_halted = 0; m_done = 0; m_ovf = 0; m_drop = 0; sum_left = 0;
        m_cyc = 0; m_inst = 0; m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0;
        prev_stall = 0; prev_data = 0;
    endtask

    // Called at a negedge with this cycle's event inputs already set.
    task automatic step(input bit rdy);
        logic        v;
        logic [15:0] d;
        int          n;
        v = bus.tx_valid;
        d = bus.tx_data;
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("tx_done", 32'(tx_done), 32'(m_done));
        if (m_done) chk("valid_after_done", 32'(v), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(v), 32'd1);
            chk("stall_data", 32'(d), 32'(prev_data));
        end
        bus.tx_ready = rdy;
        if (v && rdy) begin
            chk("word_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) chk("word", 32'(d), 32'(expq.pop_front()));
            log_q.push_back(d);
            log_t.push_back(step_no);
            if (ent_left.size() != 0) begin
                ent_left[0] = ent_left[0] - 1;
                if (ent_left[0] == 0) void'(ent_left.pop_front());
            end else if (sum_left > 0) begin
                sum_left--;
                if (sum_left == 0) m_done = 1;
            end
        end
        prev_stall = v && !rdy;
        prev_data  = d;
        if (!m_halted) begin
            if (reg_wr || mem_rd || mem_wr) begin
                if (ent_left.size() < DEPTH) begin
                    n = 0;
                    if (reg_wr) begin
                        expq.push_back({4'h1, 9'h0, reg_id}); expq.push_back(reg_data); n += 2;
                    end
                    if (mem_rd) begin
                        expq.push_back(16'h2000); expq.push_back(mem_addr);
                        expq.push_back(mem_rdata); n += 3;
                    end
                    if (mem_wr) begin
                        expq.push_back(16'h3000); expq.push_back(mem_addr);
                        expq.push_back(mem_wdata); n += 3;
                    end
                    ent_left.push_back(n);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            m_cyc = m_cyc + 1;
            if (halt || reg_wr || mem_wr) m_inst = m_inst + 1;
            m_icr = m_icr + 16'(ic_req); m_ich = m_ich + 16'(ic_hit);
            m_dcr = m_dcr + 16'(dc_req); m_dch = m_dch + 16'(dc_hit);
            if (halt) begin
                m_halted = 1;
                expq.push_back(16'hF000);
                expq.push_back(m_cyc[31:16]);  expq.push_back(m_cyc[15:0]);
                expq.push_back(m_inst[31:16]); expq.push_back(m_inst[15:0]);
                sum_left = 5;
`ifdef TRACE_CACHE_STATS_EN
                expq.push_back(m_icr); expq.push_back(m_ich);
                expq.push_back(m_dcr); expq.push_back(m_dch);
                sum_left = 9;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        step_no++;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr_in();
        bus.tx_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drain(input string tag, input int max);
        int k = 0;
        clr_in();
        while ((expq.size() != 0 || (m_halted && !m_done)) && k < max) begin
            step(1);
            k++;
        end
        chk({tag, "_left"}, 32'(expq.size()), 32'd0);
        repeat (3) step(1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < log_q.size(); i++)
            chk(tag, 32'(log_q[i]), 32'(want[i]));
    endtask

    int s_ev;

    initial begin
        clr_in();
        bus.tx_ready = 0;
        model_clear();
        @(negedge clk);
        do_reset();
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);

        // single REG
        reg_wr = 1; reg_id = 5; reg_data = 16'hBEEF; s_ev = step_no;
        step(1);
        drain("single", 20);
        want = '{16'h1005, 16'hBEEF};
        check_log("single");
        if (log_t.size() >= 2) begin
            chk("single_lat", 32'(log_t[0] - s_ev), 32'd2);
            chk("single_b2b", 32'(log_t[1] - log_t[0]), 32'd1);
        end

        // REG + LOAD in one cycle
        log_q.delete(); log_t.delete();
        reg_wr = 1; reg_id = 2; reg_data = 16'h0042;
        mem_rd = 1; mem_addr = 16'h0100; mem_rdata = 16'h0042;
        step(1);
        drain("combo", 20);
        want = '{16'h1002, 16'h0042, 16'h2000, 16'h0100, 16'h0042};
        check_log("combo");
        if (log_t.size() >= 5) chk("combo_gapless", 32'(log_t[4] - log_t[0]), 32'd4);

        // STORE under backpressure
        log_q.delete(); log_t.delete();
        mem_wr = 1; mem_addr = 16'h0010; mem_wdata = 16'h1234;
        step(0);
        clr_in();
        step(0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.tx_valid), 32'd1);
            chk("bp_data", 32'(bus.tx_data), 32'h3000);
            step(0);
        end
        drain("bp", 20);
        want = '{16'h3000, 16'h0010, 16'h1234};
        check_log("bp");

        // overflow: 10 REG cycles with the sink stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            reg_wr = 1; reg_id = 3'(i); reg_data = 16'($urandom);
            step(0);
        end
        clr_in();
        step(0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_cnt), 32'd2);
        drain("ovf", 60);
        chk("ovf_words", 32'(log_q.size()), 32'd16);
        for (int k = 0; k < 8 && 2 * k < log_q.size(); k++)
            chk("ovf_hdr", 32'(log_q[2*k]), 32'h1000 | 32'(k));

        // halt summary
        do_reset();
        s_ev = 0;
        for (int s = 1; s <= 10; s++) begin
            clr_in();
            if (s <= 3) begin reg_wr = 1; reg_id = 3'(s); reg_data = 16'(s * 256); end
            if (s == 10) begin halt = 1; s_ev = step_no; end
            step(1);
        end
        drain("halt", 40);
        want = '{16'h1001, 16'h0100, 16'h1002, 16'h0200, 16'h1003, 16'h0300,
                 16'hF000, 16'h0000, 16'h000A, 16'h0000, 16'h0004};
`ifdef TRACE_CACHE_STATS_EN
        for (int i = 0; i < 4; i++) want.push_back(16'h0000);
`endif
        check_log("halt");
        if (log_t.size() > 6) chk("halt_lat", 32'(log_t[6] - s_ev), 32'd2);
        chk("halt_done", 32'(tx_done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            halt = 1; reg_wr = 1; reg_id = 1;
            step(1);
        end
        clr_in();
        step(1);
        chk("done_hold", 32'(tx_done), 32'd1);
        chk("done_quiet", 32'(bus.tx_valid), 32'd0);

        // reset between LOAD header and its address word
        do_reset();
        mem_rd = 1; mem_addr = 16'hABCD; mem_rdata = 16'h5555;
        step(1);
        clr_in();
        for (int k = 0; k < 10 && log_q.size() < 1; k++) step(1);
        chk("mr_hdr", 32'(log_q.size()), 32'd1);
        chk("mr_pending", 32'(bus.tx_valid), 32'd1);
        rst_n = 0;
        #1;
        chk("mr_valid", 32'(bus.tx_valid), 32'd0);
        chk("mr_data", 32'(bus.tx_data), 32'd0);
        chk("mr_done", 32'(tx_done), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        chk("mr_drop", 32'(drop_cnt), 32'd0);
        do_reset();
        reg_wr = 1; reg_id = 7; reg_data = 16'h1111;
        step(1);
        drain("mr_after", 20);
        want = '{16'h1007, 16'h1111};
        check_log("mr_after");

        // randomized traffic, then halt and drain
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reg_wr    = ($urandom_range(0, 99) < 30);
            mem_rd    = ($urandom_range(0, 99) < 25);
            mem_wr    = ($urandom_range(0, 99) < 25);
            reg_id    = 3'($urandom);
            reg_data  = 16'($urandom);
            mem_addr  = 16'($urandom);
            mem_wdata = 16'($urandom);
            mem_rdata = 16'($urandom);
            ic_req    = 1'($urandom); ic_hit = 1'($urandom);
            dc_req    = 1'($urandom); dc_hit = 1'($urandom);
            step($urandom_range(0, 99) < 60);
        end
        halt = 1; reg_wr = 1; reg_id = 4; reg_data = 16'hCAFE;
        step(1);
        drain("rand", 400);
        chk("rand_done", 32'(tx_done), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
